// File: rtl/cpu_sys_clk_pkg.sv
// Shared state encoding and default timing constants for the cpu_sys PLL
// supervisor / reset sequencer.
package cpu_sys_clk_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } pll_seq_state_t;

  localparam int PLL_RST_CYC_DEF = 8;
  localparam int LOCK_FILTER_DEF = 256;
  localparam int STAGGER_DEF     = 16;

endpackage

// File: rtl/cpu_sys_sync2.sv
// Two-flop synchroniser, DATA_W bits wide, asynchronous active-low reset.
module cpu_sys_sync2 #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] sync_p0;
  logic [DATA_W-1:0] sync_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/cpu_sys_pll_rst_seq.sv
// PLL supervisor and staggered channel reset sequencer for cpu_sys.
// Optional lock timeout/retry enabled by `define CPU_SYS_PLL_RST_SEQ_TIMEOUT_EN.
module cpu_sys_pll_rst_seq
  import cpu_sys_clk_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int LOCK_FILTER = LOCK_FILTER_DEF,
  parameter int STAGGER     = STAGGER_DEF,
  parameter int PLL_RST_CYC = PLL_RST_CYC_DEF,
  parameter int LOSS_CNT_W  = 8
`ifdef CPU_SYS_PLL_RST_SEQ_TIMEOUT_EN
  , parameter int LOCK_TIMEOUT = 65536
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset,
  output logic                  pll_rst,
  output logic [NUM_CH-1:0]     ch_reset_n,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [1:0]            state
`ifdef CPU_SYS_PLL_RST_SEQ_TIMEOUT_EN
  , output logic                lock_timeout
`endif
);

  localparam int RST_W  = $clog2(PLL_RST_CYC + 1);
  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int STG_W  = $clog2(STAGGER + 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYC - 1);
  localparam logic [FILT_W-1:0] FILT_DONE = FILT_W'(LOCK_FILTER);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER - 1);

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + LOSS_CNT_W'(1);
  endfunction

  pll_seq_state_t    cur_st;
  logic              lock_s;
  logic [RST_W-1:0]  rst_cnt;
  logic [FILT_W-1:0] filt_cnt;
  logic [STG_W-1:0]  stg_cnt;
  logic              lock_loss;
  logic              go_rst;
  logic              to_hit;
  logic              restart;

  cpu_sys_sync2 #(.DATA_W(1)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  // Loss only matters once channels may be out of reset; sw_reset is ignored in PLL_RST.
  always_comb begin
    lock_loss = 1'b0;
    go_rst    = 1'b0;
    if (cur_st == ST_RELEASE || cur_st == ST_RUN) lock_loss = !lock_s;
    if (cur_st != ST_PLL_RST) go_rst = lock_loss | sw_reset;
  end

`ifdef CPU_SYS_PLL_RST_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt;
  assign to_hit = (cur_st == ST_WAIT_LOCK) && (to_cnt == TO_LAST) && (filt_cnt != FILT_DONE);
`else
  assign to_hit = 1'b0;
`endif

  assign restart = go_rst | to_hit;
  assign state   = cur_st;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_st        <= ST_PLL_RST;
      pll_rst       <= 1'b1;
      ch_reset_n    <= '0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
      rst_cnt       <= '0;
      filt_cnt      <= '0;
      stg_cnt       <= '0;
`ifdef CPU_SYS_PLL_RST_SEQ_TIMEOUT_EN
      to_cnt        <= '0;
      lock_timeout  <= 1'b0;
`endif
    end else if (restart) begin
      cur_st     <= ST_PLL_RST;
      pll_rst    <= 1'b1;
      ch_reset_n <= '0;
      ready      <= 1'b0;
      rst_cnt    <= '0;
      filt_cnt   <= '0;
      stg_cnt    <= '0;
      if (lock_loss) lock_loss_cnt <= sat_inc(lock_loss_cnt);
`ifdef CPU_SYS_PLL_RST_SEQ_TIMEOUT_EN
      to_cnt <= '0;
      if (to_hit) lock_timeout <= 1'b1;
`endif
    end else begin
      case (cur_st)
        ST_PLL_RST: begin
          if (rst_cnt == RST_LAST) begin
            cur_st  <= ST_WAIT_LOCK;
            pll_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (filt_cnt == FILT_DONE) begin
            cur_st     <= ST_RELEASE;
            ch_reset_n <= NUM_CH'(1);
          end else begin
            filt_cnt <= lock_s ? filt_cnt + FILT_W'(1) : '0;
          end
`ifdef CPU_SYS_PLL_RST_SEQ_TIMEOUT_EN
          to_cnt <= to_cnt + TO_W'(1);
`endif
        end
        // Channels release as a thermometer code, one more every STAGGER cycles.
        ST_RELEASE: begin
          if (ch_reset_n[NUM_CH-1]) begin
            cur_st <= ST_RUN;
            ready  <= 1'b1;
          end else if (stg_cnt == STG_LAST) begin
            stg_cnt    <= '0;
            ch_reset_n <= (ch_reset_n << 1) | NUM_CH'(1);
          end else begin
            stg_cnt <= stg_cnt + STG_W'(1);
          end
        end
        ST_RUN: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_sys_pll_rst_seq.md
# cpu_sys_pll_rst_seq

Parametrised PLL supervisor and reset sequencer that sits between the system PLL wrapper and every clock-domain consumer in `cpu_sys`. It holds the PLL in reset, then waits for a filtered lock. It releases N downstream channel resets one after another at fixed spacing, and raises `ready`. It watches for lock loss at runtime, counts events and re-sequences automatically. It also accepts a software re-sequence request.

## Interface
Parameters:
- `NUM_CH`, 2: number of sequenced channel resets (1..16).
- `LOCK_FILTER`, 256: consecutive synchronised-lock-high cycles required before release (≥1).
- `STAGGER`, 16: cycles between successive channel releases (≥1).
- `PLL_RST_CYC`, 8: cycles `pll_rst` is held asserted per attempt (≥1).
- `LOSS_CNT_W`, 8: width of the lock-loss counter.

Ports:
- `clk`, in, 1: single clock; all logic runs here.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `pll_locked`, in, 1: raw PLL lock, asynchronous to `clk`.
- `sw_reset`, in, 1: synchronous single-cycle re-sequence request.
- `pll_rst`, out, 1: active-high reset to the PLL.
- `ch_reset_n`, out, NUM_CH: per-channel active-low resets, registered.
- `ready`, out, 1: all channels released, PLL locked.
- `lock_loss_cnt`, out, LOSS_CNT_W: saturating count of runtime lock losses.
- `state`, out, 2: current FSM state encoding.

## Operation
- `pll_locked` passes through a 2-flop synchroniser, giving `lock_s`.
- The FSM has four states: PLL_RST=0, WAIT_LOCK=1, RELEASE=2, RUN=3.
- **PLL_RST:** `pll_rst`=1, all `ch_reset_n`=0, `ready`=0. After PLL_RST_CYC cycles the FSM goes to WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0. A filter counter increments while `lock_s`=1 and clears to 0 on any `lock_s`=0. When it reaches LOCK_FILTER, the FSM goes to RELEASE.
- **RELEASE:** a stagger counter runs.
  - `ch_reset_n[0]` rises on the first RELEASE cycle.
  - `ch_reset_n[k]` rises k·STAGGER cycles later.
  - Released channels stay high.
  - After `ch_reset_n[NUM_CH-1]` rises, the FSM goes to RUN.
  - If `lock_s` falls during RELEASE, this counts as lock loss (same handling as in RUN).
- **RUN:** `ready`=1.
- **Lock loss** (`lock_s`=0 in RELEASE or RUN):
  - `lock_loss_cnt` increments, saturating at all-ones.
  - All `ch_reset_n` and `ready` drop together.
  - The FSM goes to PLL_RST.
- **`sw_reset`=1** in WAIT_LOCK, RELEASE or RUN sends the FSM to PLL_RST without counting. It is ignored in PLL_RST.
- If lock loss and `sw_reset` occur in the same cycle, the loss is counted. There is a single transition to PLL_RST.
- All counters clear on every entry to PLL_RST. `lock_loss_cnt` is cleared only by `reset_n`.

## Timing
- Reset values:
  - `pll_rst`=1.
  - `ch_reset_n`=all 0.
  - `ready`=0.
  - `lock_loss_cnt`=0.
  - `state`=0 (PLL_RST).
- `reset_n` assertion mid-sequence forces these values asynchronously, within the same cycle.
- Raw lock to `lock_s`: 2 cycles.
- Raw lock rise to `ch_reset_n[0]` rise: 2 + LOCK_FILTER + 1 cycles.
- `ready` rises 1 cycle after `ch_reset_n[NUM_CH-1]` rises.
- Lock loss or `sw_reset` to `ch_reset_n`=0, `ready`=0, `pll_rst`=1: 1 cycle after `lock_s`=0 or `sw_reset` is sampled. For lock loss this is 3 cycles from the raw `pll_locked` fall.
- `state` is registered and updates in the same cycle as the outputs.

## Configuration
- Macro: `CPU_SYS_PLL_RST_SEQ_TIMEOUT_EN`.
- **Defined:**
  - Adds parameter `LOCK_TIMEOUT` (default 65536) and output `lock_timeout` (1 bit, sticky, reset 0, cleared only by `reset_n`).
  - When WAIT_LOCK has lasted LOCK_TIMEOUT cycles without passing the filter, `lock_timeout` is set and the FSM goes to PLL_RST to retry the PLL.
- **Undefined:** WAIT_LOCK waits indefinitely. Neither the parameter nor the port exists.

## Structure
- Package `cpu_sys_clk_pkg` holds:
  - the state typedef (`pll_seq_state_t`, 2-bit enum with the encodings above);
  - default constants for PLL_RST_CYC and LOCK_FILTER.
- One sub-module, `cpu_sys_sync2`: a parametrised-width 2-flop synchroniser with async active-low reset, used for `pll_locked`.

## Test plan
Bench parameters: NUM_CH=3, LOCK_FILTER=16, STAGGER=4, PLL_RST_CYC=8.

- **Power-up:** release `reset_n`; `pll_locked` rises at cycle 20.
  - `pll_rst` is high for cycles 0–7.
  - `ch_reset_n[0]` rises at 39, `[1]` at 43, `[2]` at 47.
  - `ready` rises at 48.
- **Filter glitch:** `pll_locked` high for 10 cycles, low 1 cycle, then high. The filter restarts, and `ch_reset_n[0]` rises 19 cycles after the second rise.
- **Runtime loss:** in RUN, drop `pll_locked`.
  - 3 cycles later: `ready`=0, `ch_reset_n`=000, `pll_rst`=1, `lock_loss_cnt`=1.
  - Re-lock re-sequences fully.
- **Simultaneous events:** `sw_reset` in the same cycle as `lock_s` falls in RUN gives `lock_loss_cnt`+1 and a single PLL_RST entry. `sw_reset` alone in RUN leaves the count unchanged.
- **Saturation and async reset:**
  - With LOSS_CNT_W=2, four losses hold `lock_loss_cnt` at 3.
  - Asserting `reset_n` during RELEASE immediately zeroes every output and sets `pll_rst`=1.
- **Timeout (macro defined, LOCK_TIMEOUT=100):** with `pll_locked` held low, `lock_timeout` sets and `pll_rst` re-asserts 100 cycles after WAIT_LOCK entry.
